// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin merge of ex/mem writeback FIFOs onto one regfile write port
module regfile_wb_arbiter_fifo #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          i_valid,
    input  logic          i_pop,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    output logic [AW-1:0] o_head_addr,
    output logic [DW-1:0] o_head_data,
    output logic [CW-1:0] o_cnt,
    output logic [31:0]   o_mask
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [AW-1:0] r_addr [DEPTH];
    logic [DW-1:0] r_data [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;
    logic          w_push;
    logic          w_pop;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction
    assign o_ready     = rst & (r_cnt < CW'(DEPTH));
    assign w_push      = i_valid & o_ready & ~flush;
    assign w_pop       = i_pop & ~flush & (r_cnt != '0);
    assign o_head_addr = r_addr[r_rd];
    assign o_head_data = r_data[r_rd];
    assign o_cnt       = r_cnt;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= nxt(r_wr);
            if (w_pop) r_rd <= nxt(r_rd);
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr] <= i_addr;
            r_data[r_wr] <= i_data;
        end
    end
    // Walk only the occupied slots, oldest first; register 0 never shows as pending.
    always_comb begin
        o_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (CW'(i) < r_cnt) o_mask[r_addr[r_rd + PW'(i)]] = 1'b1;
        o_mask[0] = 1'b0;
    end
endmodule

module regfile_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int AW    = 5,
    parameter int DW    = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   ex_valid,
    output logic                   ex_ready,
    input  logic [AW-1:0]          ex_addr,
    input  logic [DW-1:0]          ex_data,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [AW-1:0]          mem_addr,
    input  logic [DW-1:0]          mem_data,
    output logic                   we,
    output logic [AW-1:0]          waddr,
    output logic [DW-1:0]          wdata,
    output logic [31:0]            pending_mask,
    output logic [$clog2(DEPTH):0] ex_cnt,
    output logic [$clog2(DEPTH):0] mem_cnt
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef enum logic {RR_EX, RR_MEM} rr_e;
    rr_e           r_rr;
    rr_e           w_rr_nxt;
    logic [AW-1:0] w_ex_addr;
    logic [DW-1:0] w_ex_data;
    logic [AW-1:0] w_mem_addr;
    logic [DW-1:0] w_mem_data;
    logic [31:0]   w_ex_mask;
    logic [31:0]   w_mem_mask;
    logic [31:0]   w_we_mask;
    logic          w_ex_ne;
    logic          w_mem_ne;
    logic          w_grant_ex;
    logic          w_grant_mem;
    logic          w_grant;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_data;
    regfile_wb_arbiter_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) u_ex (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(ex_valid), .i_pop(w_grant_ex),
        .i_addr(ex_addr), .i_data(ex_data), .o_ready(ex_ready), .o_head_addr(w_ex_addr),
        .o_head_data(w_ex_data), .o_cnt(ex_cnt), .o_mask(w_ex_mask)
    );
    regfile_wb_arbiter_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .CW(CW)) u_mem (
        .clk(clk), .rst(rst), .flush(flush), .i_valid(mem_valid), .i_pop(w_grant_mem),
        .i_addr(mem_addr), .i_data(mem_data), .o_ready(mem_ready), .o_head_addr(w_mem_addr),
        .o_head_data(w_mem_data), .o_cnt(mem_cnt), .o_mask(w_mem_mask)
    );
    assign w_ex_ne      = ex_cnt != '0;
    assign w_mem_ne     = mem_cnt != '0;
    assign w_grant_ex   = w_ex_ne & (~w_mem_ne | (r_rr == RR_EX));
    assign w_grant_mem  = w_mem_ne & ~w_grant_ex;
    assign w_grant      = w_grant_ex | w_grant_mem;
    assign w_sel_addr   = w_grant_ex ? w_ex_addr : w_mem_addr;
    assign w_sel_data   = w_grant_ex ? w_ex_data : w_mem_data;
    assign w_we_mask    = we ? (32'd1 << waddr) : 32'd0;
    assign pending_mask = w_ex_mask | w_mem_mask | w_we_mask;
    // Priority flips only when both sources actually competed for the slot.
    always_comb begin
        w_rr_nxt = r_rr;
        if (!flush && w_ex_ne && w_mem_ne) w_rr_nxt = (r_rr == RR_EX) ? RR_MEM : RR_EX;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_rr <= RR_EX;
        else r_rr <= w_rr_nxt;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (flush) begin
            we <= 1'b0;
        end else begin
            we <= w_grant & (w_sel_addr != '0);
            if (w_grant) begin
                waddr <= w_sel_addr;
                wdata <= w_sel_data;
            end
        end
    end
endmodule
